// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) doubling for the AES-128 key schedule.
package aes_pkg;

    localparam int unsigned AES_NR    = 10;
    localparam int unsigned AES_KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FIN
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reloads to 01 on a new key, doubles in GF(2^8) per round advance.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       adv_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcon_q <= 8'h01;
        end else if (load_i) begin
            rcon_q <= 8'h01;
        end else if (adv_i) begin
            rcon_q <= xtime(rcon_q);
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion emitting round keys 0..NR over valid/ready.
// Optional key store with read port enabled by AES_KS_STORE_EN.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int unsigned NR    = AES_NR,
    parameter int unsigned KEY_W = AES_KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic [31:0]      sub_word_out,
    input  logic [31:0]      sub_word_in,
    output logic [KEY_W-1:0] rk,
    output logic [3:0]       rk_round,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy,
    output logic             done
`ifdef AES_KS_STORE_EN
    ,
    input  logic [3:0]       rd_addr,
    output logic [KEY_W-1:0] rd_key,
    output logic             keys_stored
`endif
);

    localparam logic [3:0] LAST = 4'(NR);

    ks_state_t        state_q, state_d;
    logic [KEY_W-1:0] rk_q, rk_d;
    logic [3:0]       round_q, round_d;
    logic [7:0]       rcon;
    logic             hs, load, adv;
    logic [31:0]      w0, w1, w2, w3, n0, n1, n2, n3;

    assign hs   = (state_q == EMIT) && rk_ready;
    assign load = (state_q == IDLE) && start;
    assign adv  = hs && (round_q != LAST);

    aes_rcon_gen u_rcon (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .adv_i  (adv),
        .rcon_o (rcon)
    );

    assign w0 = rk_q[KEY_W-1 -: 32];
    assign w1 = rk_q[KEY_W-33 -: 32];
    assign w2 = rk_q[KEY_W-65 -: 32];
    assign w3 = rk_q[31:0];

    assign n0 = w0 ^ sub_word_in ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                    rk_d    = key_in;
                    round_d = '0;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (round_q == LAST) begin
                        state_d = FIN;
                    end else begin
                        rk_d    = {n0, n1, n2, n3};
                        round_d = round_q + 4'd1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rk_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
        end
    end

    // Handshake outputs decode the state register only, so rk_ready never reaches rk_valid.
    assign sub_word_out = {w3[23:0], w3[31:24]};
    assign rk           = rk_q;
    assign rk_round     = round_q;
    assign rk_valid     = (state_q == EMIT);
    assign busy         = (state_q == EMIT);
    assign done         = (state_q == FIN);

`ifdef AES_KS_STORE_EN
    logic [KEY_W-1:0] mem_q [0:NR];
    logic [KEY_W-1:0] rd_key_q;
    logic             stored_q;

    // Contents survive reset so a decryptor can still read a completed schedule.
    always_ff @(posedge clk) begin
        if (hs) begin
            mem_q[round_q] <= rk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_key_q <= '0;
            stored_q <= 1'b0;
        end else begin
            rd_key_q <= (rd_addr <= LAST) ? mem_q[rd_addr] : '0;
            if (load) begin
                stored_q <= 1'b0;
            end else if (state_q == FIN) begin
                stored_q <= 1'b1;
            end
        end
    end

    assign rd_key      = rd_key_q;
    assign keys_stored = stored_q;
`endif

endmodule

// File: doc/aes_key_sched.md
Name: aes_key_sched

Overview:
- Iterative AES-128 key-expansion controller.
- Holds the current round key and drives the rotated last word, RotWord(w3), to the key-path S-box inputs (KC..KF) of SboxK.
- Consumes the substituted word from SboxK (KAC..KAF), applies Rcon, and produces round keys 0..10 one at a time over a valid/ready handshake.
- Its consumer is the round datapath AddRoundKey stage.

Parameters:
- NR, 10, number of rounds; round keys 0..NR are emitted.
- KEY_W, 128, key and round-key width; fixed for AES-128.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  one-cycle request to begin expansion of key_in.
- key_in  input  128  cipher key; byte 0 is at bits [127:120].
- sub_word_out  output  32  RotWord(w3) of the current key; bytes [31:24],[23:16],[15:8],[7:0] drive KC,KD,KE,KF.
- sub_word_in  input  32  SubWord result from SboxK; bytes KAC,KAD,KAE,KAF map to [31:24]..[7:0]; combinational, same cycle.
- rk  output  128  current round key.
- rk_round  output  4  index of rk, 0..NR.
- rk_valid  output  1  rk and rk_round are valid.
- rk_ready  input  1  consumer accepts rk when rk_valid and rk_ready are both high on a clock edge.
- busy  output  1  high from start acceptance until the last key is accepted.
- done  output  1  one-cycle pulse after round key NR is accepted.

Behaviour:
- Reset (rst_n low at an edge): state = IDLE; rk = 0; rk_round = 0; rk_valid = 0; busy = 0; done = 0; rcon = 8'h01. Reset mid-expansion aborts at once; no further keys are emitted.
- FSM states: IDLE, EMIT, FIN.
- IDLE:
  - start high at edge T → load rk = key_in, rk_round = 0, rcon = 8'h01, go to EMIT.
  - rk_valid = 1 and busy = 1 from T+1.
  - start with rst_n low is ignored.
- EMIT:
  - rk_valid = 1.
  - Handshake with rk_round < NR:
    - w0' = w0 ^ sub_word_in ^ {rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
    - rk ← {w0',w1',w2',w3'}; rk_round increments.
    - rcon ← xtime(rcon): shift left, XOR 8'h1B if bit7 was set, so 8'h80 → 8'h1B and 8'h1B → 8'h36.
  - Handshake with rk_round == NR → go to FIN.
  - rk_ready low: rk, rk_round and rcon hold; rk_valid stays high (no retraction).
- FIN: done = 1 for one cycle; rk_valid = 0; busy = 0; next state IDLE. rk keeps the last key.
- Throughput: with rk_ready held high, one key per cycle; key r is valid at cycle T+1+r; done is at T+NR+2.
- start while busy is ignored. start in the same cycle as FIN is ignored; it is accepted only in IDLE.
- sub_word_out = {w3[23:0], w3[31:24]}, purely combinational from the rk register.
- No combinational path from rk_ready to rk_valid.

Optional Feature:
- Macro: AES_KS_STORE_EN.
- Defined:
  - Adds an internal 11×128 register array written at each handshake with the accepted rk.
  - Adds ports rd_addr (input, 4) and rd_key (output, 128). rd_key = array[rd_addr], registered with one-cycle latency; rd_addr > NR returns 0.
  - Adds output keys_stored (1): set at done, cleared at start acceptance or reset. This supports reverse-order decryption schedules.
  - Array contents are not cleared by reset.
- Undefined: none of these ports or the array exist; behaviour is otherwise identical.

Decomposition:
- Package aes_pkg:
  - constants AES_NR = 10, AES_KEY_W = 128;
  - state enum type ks_state_t {IDLE, EMIT, FIN};
  - function xtime(byte).
- One natural sub-module: aes_rcon_gen (rcon register with load/advance). The word XOR chain stays inline.
- The S-box is not instantiated here. It is wired at the parent alongside SboxK.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready = 1; bench loops sub_word_out through SboxK K-path → rk_round 0 = key; sub_word_out = cf4f3c09, sub_word_in = 8a84eb01; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done at T+12.
- Same key with rk_ready toggling 1,0,0,1,… → rk stable and rk_valid high through stalls; sequence identical to the first test; rcon values 01,02,…,80,1B,36 checked internally.
- start pulsed again at round 4 → ignored; expansion completes unchanged; a second start after done restarts from round 0.
- rst_n low at round 6 → next cycle rk_valid = 0, busy = 0, rk = 0; no done pulse; a fresh start behaves as in the first test.
- All-zero key → round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- With AES_KS_STORE_EN: after the first test, rd_addr = 10 → rd_key = d014f9a8… one cycle later; rd_addr = 0 → original key; rd_addr = 15 → 0; keys_stored = 1.
